// File: rtl/audio_i2s_tx.sv
// I2S transmitter: two-entry sample FIFO, bit-clock divider and 32-slot
// frame serializer. Left channel in x[31:16], right channel in x[15:0].
module audio_i2s_tx #(
    parameter int unsigned DIV = 4
) (
    input  logic        c,
    input  logic        r,
    input  logic [31:0] x,
    input  logic        v,
    output logic        rdy,
    output logic        bck,
    output logic        lrck,
    output logic        sd,
    output logic        ur
);

    logic [7:0]  dc;
    logic [4:0]  slot;
    logic [31:0] sr;
    logic [1:0]  cnt;
    logic [31:0] mem0;
    logic [31:0] mem1;

    logic tick;
    logic fall;
    logic load;
    logic push;
    logic pop;

    // Tick ends each bck half-period; the falling tick advances the frame.
    assign tick = (dc == 8'(DIV - 1));
    assign fall = tick && bck;
    // Load on the falling tick that enters slot 1 (one-bit I2S delay).
    assign load = fall && (slot == 5'd0);
    assign pop  = load && (cnt != 2'd0);
    assign push = v && rdy;

    assign rdy  = !r && (cnt != 2'd2);
    assign lrck = slot[4];
    assign sd   = sr[31];

    // Divider counter and bit clock.
    always_ff @(posedge c) begin
        if (r) begin
            dc  <= 8'd0;
            bck <= 1'b0;
        end else if (tick) begin
            dc  <= 8'd0;
            bck <= ~bck;
        end else begin
            dc  <= dc + 8'd1;
        end
    end

    // Slot counter, wraps every 32 bit periods.
    always_ff @(posedge c) begin
        if (r) begin
            slot <= 5'd0;
        end else if (fall) begin
            slot <= slot + 5'd1;
        end
    end

    // Output shift register: load a new frame word or shift MSB-first.
    always_ff @(posedge c) begin
        if (r) begin
            sr <= 32'd0;
        end else if (load) begin
            sr <= pop ? mem0 : 32'd0;
        end else if (fall) begin
            sr <= {sr[30:0], 1'b0};
        end
    end

    // Underrun pulse when a frame load finds the FIFO empty.
    always_ff @(posedge c) begin
        if (r) begin
            ur <= 1'b0;
        end else begin
            ur <= load && (cnt == 2'd0);
        end
    end

    // Two-entry FIFO; mem0 is always the head.
    always_ff @(posedge c) begin
        if (r) begin
            cnt  <= 2'd0;
            mem0 <= 32'd0;
            mem1 <= 32'd0;
        end else if (push && pop) begin
            // Only reachable with one entry: new word becomes the head.
            mem0 <= x;
        end else if (push) begin
            if (cnt == 2'd0) begin
                mem0 <= x;
            end else begin
                mem1 <= x;
            end
            cnt <= cnt + 2'd1;
        end else if (pop) begin
            mem0 <= mem1;
            cnt  <= cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomized and directed bench for audio_i2s_tx against a timing/queue model.
module tb_audio_i2s_tx;

    localparam int DIV  = 2;
    localparam int DIV3 = 3;

    logic        c = 1'b0;
    logic        r;
    logic [31:0] x;
    logic        v;
    logic        rdy, bck, lrck, sd, ur;
    logic        rdy3, bck3, lrck3, sd3, ur3;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          t = 0;
    int          rst_cycles = 0;
    logic [31:0] q[$];
    logic [31:0] lw[$];
    bit          lu[$];

    always #5 c = ~c;

    audio_i2s_tx #(.DIV(DIV)) dut (
        .c(c), .r(r), .x(x), .v(v),
        .rdy(rdy), .bck(bck), .lrck(lrck), .sd(sd), .ur(ur)
    );

    audio_i2s_tx #(.DIV(DIV3)) dut3 (
        .c(c), .r(r), .x(32'd0), .v(1'b0),
        .rdy(rdy3), .bck(bck3), .lrck(lrck3), .sd(sd3), .ur(ur3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    function automatic bit exp_rdy();
        return q.size() < 2;
    endfunction

    function automatic bit is_load(input int tt, input int d);
        return (tt + 1 >= 2 * d) && (((tt + 1 - 2 * d) % (64 * d)) == 0);
    endfunction

    // One cycle: drive inputs, check outputs at negedge, then advance the model.
    task automatic step(input bit rr, input bit vv, input logic [31:0] xx);
        int          f;
        int          n;
        logic [31:0] w;
        logic        e_sd;
        logic        e_ur;
        bit          re;
        r = rr;
        v = vv;
        x = xx;
        @(negedge c);
        if (rr) begin
            check_eq("rdy_rst", rdy, 0);
            check_eq("rdy3_rst", rdy3, 0);
            if (rst_cycles > 0) begin
                check_eq("out_rst", {bck, lrck, sd, ur}, 0);
                check_eq("out3_rst", {bck3, lrck3, sd3, ur3}, 0);
            end
        end else begin
            f = t / (2 * DIV);
            if (f == 0) begin
                e_sd = 1'b0;
            end else begin
                w    = lw[(f - 1) / 32];
                e_sd = w[31 - ((f - 1) % 32)];
            end
            e_ur = 1'b0;
            if (t >= 2 * DIV && ((t - 2 * DIV) % (64 * DIV)) == 0) begin
                n    = (t - 2 * DIV) / (64 * DIV);
                e_ur = lu[n];
            end
            check_eq("rdy", rdy, exp_rdy());
            check_eq("bck", bck, (t / DIV) % 2);
            check_eq("lrck", lrck, (f % 32) >= 16);
            check_eq("sd", sd, e_sd);
            check_eq("ur", ur, e_ur);
            // Second instance: never fed, so it underruns every frame.
            check_eq("rdy3", rdy3, 1);
            check_eq("bck3", bck3, (t / DIV3) % 2);
            check_eq("lrck3", lrck3, ((t / (2 * DIV3)) % 32) >= 16);
            check_eq("sd3", sd3, 0);
            check_eq("ur3", ur3, (t >= 2 * DIV3) && (((t - 2 * DIV3) % (64 * DIV3)) == 0));
        end
        @(posedge c);
        #1;
        if (rr) begin
            t = 0;
            q.delete();
            lw.delete();
            lu.delete();
            rst_cycles++;
        end else begin
            re = exp_rdy();
            if (is_load(t, DIV)) begin
                if (q.size() > 0) begin
                    lw.push_back(q.pop_front());
                    lu.push_back(1'b0);
                end else begin
                    lw.push_back(32'd0);
                    lu.push_back(1'b1);
                end
            end
            if (vv && re) q.push_back(xx);
            t++;
            rst_cycles = 0;
        end
    endtask

    initial begin
        logic [31:0] next_w;
        int          guard;
        r = 1'b1;
        v = 1'b0;
        x = 32'd0;
        @(posedge c);
        #1;
        repeat (4) step(1, 0, 0);

        // Single word right after reset, then starve into underruns.
        step(0, 1, 32'hA5A5_3C3C);
        repeat (3 * 64 * DIV) step(0, 0, 0);
        step(0, 1, 32'h8000_0001);
        repeat (2 * 64 * DIV) step(0, 0, 0);

        // Backpressure: source holds v high, advancing only on acceptance.
        repeat (2) step(1, 0, 0);
        next_w = 32'h1000_0000;
        repeat (4 * 64 * DIV) begin
            bit acc;
            acc = exp_rdy();
            step(0, 1, next_w);
            if (acc) next_w++;
        end

        // Reset for one cycle at slot 20 with the FIFO full.
        guard = 0;
        while (!(((t / (2 * DIV)) % 32) == 20 && q.size() == 2) && guard < 64 * DIV) begin
            bit acc;
            acc = exp_rdy();
            step(0, 1, next_w);
            if (acc) next_w++;
            guard++;
        end
        check_eq("slot20_reached", guard < 64 * DIV, 1);
        step(1, 1, next_w);
        repeat (2 * 64 * DIV) step(0, 0, 0);

        // Push/pop collision: one word mid-frame plus a push on each load cycle.
        repeat (2) step(1, 0, 0);
        repeat (5 * 64 * DIV) begin
            bit hit;
            hit = ((t % (64 * DIV)) == 60) || is_load(t, DIV);
            step(0, hit, $urandom);
        end

        // Random sparse traffic.
        repeat (3000) step(0, $urandom_range(0, 99) < 2, $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
